// File: rtl/handle_translator_if.sv
// Request/response bundle between the core memory port, the handle
// translator and the downstream memory bus. The translator takes the
// "slave" view; the surrounding core/bus model takes the "master" view.
interface handle_translator_if #(
    parameter int ADDR_WIDTH = 16
);
    // Upstream request side
    logic                  i_valid;
    logic                  o_ready;
    logic [1:0]            i_op;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [ADDR_WIDTH-1:0] i_data;

    // Downstream transaction side
    logic                  o_valid;
    logic                  i_ready;
    logic [1:0]            o_op;
    logic [ADDR_WIDTH-1:0] o_address;
    logic [ADDR_WIDTH-1:0] o_data;

    // Command results and fault reporting
    logic                  o_resp_valid;
    logic [ADDR_WIDTH-1:0] o_resp_data;
    logic                  o_fault;
    logic [1:0]            o_fault_code;

    modport slave (
        input  i_valid, i_op, i_address, i_data, i_ready,
        output o_ready, o_valid, o_op, o_address, o_data,
        output o_resp_valid, o_resp_data, o_fault, o_fault_code
    );

    modport master (
        output i_valid, i_op, i_address, i_data, i_ready,
        input  o_ready, o_valid, o_op, o_address, o_data,
        input  o_resp_valid, o_resp_data, o_fault, o_fault_code
    );
endinterface

// File: rtl/handle_translator.sv
// Handle-to-physical address translator.
// Address MSB clear: physical access, passed through unchanged.
// Address MSB set, handle field all-ones: table command (alloc / base / limit).
// Address MSB set otherwise: handle access, translated to base + offset.
// Optional feature macro: HANDLE_BOUNDS_CHECK_EN (stores per-handle limits
// and raises BOUNDS faults); when undefined limits are neither stored nor
// checked and limit reads return 0.
module handle_translator #(
    parameter int ADDR_WIDTH  = 16,
    parameter int HNDL_WIDTH  = 3,
    parameter int NUM_HANDLES = 7
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    handle_translator_if.slave   bus
);
    localparam int OFFS_WIDTH = ADDR_WIDTH - HNDL_WIDTH - 1;

    localparam logic [HNDL_WIDTH-1:0] ID_ALL_ONES = '1;
    localparam logic [HNDL_WIDTH:0]   NUM_H       = (HNDL_WIDTH+1)'(NUM_HANDLES);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_BAD_HANDLE = 2'd1,
        FAULT_BOUNDS     = 2'd2,
        FAULT_NO_HANDLE  = 2'd3
    } fault_e;

    // Handle table
    logic [NUM_HANDLES-1:0] alloc_q, alloc_d;
    logic [ADDR_WIDTH-1:0]  base_q [NUM_HANDLES];
    logic [ADDR_WIDTH-1:0]  base_d [NUM_HANDLES];
`ifdef HANDLE_BOUNDS_CHECK_EN
    logic [OFFS_WIDTH:0]    limit_q [NUM_HANDLES];
    logic [OFFS_WIDTH:0]    limit_d [NUM_HANDLES];
`endif

    // Registered outputs
    logic                  o_valid_q, o_valid_d;
    logic [1:0]            o_op_q, o_op_d;
    logic [ADDR_WIDTH-1:0] o_address_q, o_address_d;
    logic [ADDR_WIDTH-1:0] o_data_q, o_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  fault_q, fault_d;
    fault_e                fault_code_q, fault_code_d;

    // Request decode
    logic                  ready;
    logic                  accept;
    logic                  is_read, is_write;
    logic                  addr_msb;
    logic [HNDL_WIDTH-1:0] hndl_field;
    logic [HNDL_WIDTH-1:0] cmd_id;
    logic                  cmd_sel;
    logic [OFFS_WIDTH-1:0] offset;
    logic                  hndl_id_ok, cmd_id_ok;
    logic [OFFS_WIDTH:0]   cmd_limit;
    logic                  bounds_hit;
    logic                  free_found;
    logic [HNDL_WIDTH-1:0] free_id;

    assign ready      = !o_valid_q || bus.i_ready;
    assign accept     = bus.i_valid && ready;
    assign is_read    = (bus.i_op == OP_READ);
    assign is_write   = (bus.i_op == OP_WRITE);
    assign addr_msb   = bus.i_address[ADDR_WIDTH-1];
    assign hndl_field = bus.i_address[ADDR_WIDTH-2 -: HNDL_WIDTH];
    assign offset     = bus.i_address[OFFS_WIDTH-1:0];
    assign cmd_id     = bus.i_address[HNDL_WIDTH-1:0];
    assign cmd_sel    = bus.i_address[HNDL_WIDTH];
    assign hndl_id_ok = ({1'b0, hndl_field} < NUM_H);
    assign cmd_id_ok  = ({1'b0, cmd_id} < NUM_H);

`ifdef HANDLE_BOUNDS_CHECK_EN
    assign cmd_limit  = limit_q[cmd_id];
    assign bounds_hit = (limit_q[hndl_field] != '0) && ({1'b0, offset} >= limit_q[hndl_field]);
`else
    assign cmd_limit  = '0;
    assign bounds_hit = 1'b0;
`endif

    // Lowest-numbered free entry, used by the allocate command
    always_comb begin
        free_found = 1'b0;
        free_id    = ID_ALL_ONES;
        for (int i = NUM_HANDLES - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                free_found = 1'b1;
                free_id    = HNDL_WIDTH'(i);
            end
        end
    end

    // Next-state for table and outputs from the accepted request
    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) before any branch, so no path can infer a latch.
        alloc_d      = alloc_q;
        base_d       = base_q;
`ifdef HANDLE_BOUNDS_CHECK_EN
        limit_d      = limit_q;
`endif
        o_valid_d    = o_valid_q && !bus.i_ready;
        o_op_d       = o_op_q;
        o_address_d  = o_address_q;
        o_data_d     = o_data_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        fault_d      = 1'b0;
        fault_code_d = FAULT_NONE;

        if (accept && (is_read || is_write)) begin
            if (!addr_msb) begin
                // Physical access: straight passthrough
                o_valid_d   = 1'b1;
                o_op_d      = bus.i_op;
                o_address_d = bus.i_address;
                o_data_d    = bus.i_data;
            end else if (hndl_field == ID_ALL_ONES) begin
                // Table command
                if (cmd_id == ID_ALL_ONES) begin
                    if (is_read) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = ADDR_WIDTH'(free_id);
                        if (free_found) begin
                            alloc_d[free_id] = 1'b1;
                            base_d[free_id]  = '0;
`ifdef HANDLE_BOUNDS_CHECK_EN
                            limit_d[free_id] = '0;
`endif
                        end else begin
                            fault_d      = 1'b1;
                            fault_code_d = FAULT_NO_HANDLE;
                        end
                    end else begin
                        fault_d      = 1'b1;
                        fault_code_d = FAULT_BAD_HANDLE;
                    end
                end else if (!cmd_id_ok) begin
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_BAD_HANDLE;
                end else if (is_read) begin
                    resp_valid_d = 1'b1;
                    if (!alloc_q[cmd_id])
                        resp_data_d = '0;
                    else if (cmd_sel)
                        resp_data_d = ADDR_WIDTH'(cmd_limit);
                    else
                        resp_data_d = base_q[cmd_id];
                end else if (!cmd_sel) begin
                    if (bus.i_data != '0) begin
                        alloc_d[cmd_id] = 1'b1;
                        base_d[cmd_id]  = bus.i_data;
                    end else begin
                        // Base of zero frees the entry completely
                        alloc_d[cmd_id] = 1'b0;
                        base_d[cmd_id]  = '0;
`ifdef HANDLE_BOUNDS_CHECK_EN
                        limit_d[cmd_id] = '0;
`endif
                    end
                end else begin
`ifdef HANDLE_BOUNDS_CHECK_EN
                    limit_d[cmd_id] = bus.i_data[OFFS_WIDTH:0];
`endif
                end
            end else begin
                // Handle access
                if (!hndl_id_ok || !alloc_q[hndl_field]) begin
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_BAD_HANDLE;
                end else if (bounds_hit) begin
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_BOUNDS;
                end else begin
                    o_valid_d   = 1'b1;
                    o_op_d      = bus.i_op;
                    o_address_d = base_q[hndl_field] + ADDR_WIDTH'(offset);
                    o_data_d    = bus.i_data;
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!i_reset_n) begin
            // NOTE: the table lives in flops and is cleared on reset so every handle reads as free afterwards.
            alloc_q      <= '0;
            base_q       <= '{default: '0};
`ifdef HANDLE_BOUNDS_CHECK_EN
            limit_q      <= '{default: '0};
`endif
            o_valid_q    <= 1'b0;
            o_op_q       <= '0;
            o_address_q  <= '0;
            o_data_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            alloc_q      <= alloc_d;
            base_q       <= base_d;
`ifdef HANDLE_BOUNDS_CHECK_EN
            limit_q      <= limit_d;
`endif
            o_valid_q    <= o_valid_d;
            o_op_q       <= o_op_d;
            o_address_q  <= o_address_d;
            o_data_q     <= o_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_valid      = o_valid_q;
    assign bus.o_op         = o_op_q;
    assign bus.o_address    = o_address_q;
    assign bus.o_data       = o_data_q;
    assign bus.o_resp_valid = resp_valid_q;
    assign bus.o_resp_data  = resp_data_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_fault_code = fault_code_q;
endmodule

// File: tb/tb_handle_translator.sv
// Testbench for handle_translator (AW=16, HW=3, 7 handles).
// Directed vector table, hand-written stall/reset sequences, and a
// randomized run checked against a behavioural table model.
// Honours HANDLE_BOUNDS_CHECK_EN the same way as the design.
`timescale 1ns/1ps
module tb_handle_translator;
    localparam int AW = 16;
`ifdef HANDLE_BOUNDS_CHECK_EN
    localparam bit BOUNDS_ON = 1'b1;
`else
    localparam bit BOUNDS_ON = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rv;
        logic [15:0] rdata;
        logic        f;
        logic [1:0]  code;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        exp_t        e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    handle_translator_if #(.ADDR_WIDTH(AW)) bus ();

    handle_translator #(
        .ADDR_WIDTH (AW),
        .HNDL_WIDTH (3),
        .NUM_HANDLES(7)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    // Behavioural table model
    bit m_alloc [7];
    int m_base  [7];
    int m_limit [7];

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, " o_valid"}, int'(bus.o_valid), int'(e.v));
        if (e.v) begin
            check({tag, " o_op"}, int'(bus.o_op), int'(e.op));
            check({tag, " o_address"}, int'(bus.o_address), int'(e.addr));
            check({tag, " o_data"}, int'(bus.o_data), int'(e.data));
        end
        check({tag, " o_resp_valid"}, int'(bus.o_resp_valid), int'(e.rv));
        if (e.rv) check({tag, " o_resp_data"}, int'(bus.o_resp_data), int'(e.rdata));
        check({tag, " o_fault"}, int'(bus.o_fault), int'(e.f));
        if (e.f) check({tag, " o_fault_code"}, int'(bus.o_fault_code), int'(e.code));
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                           input logic v, input logic [15:0] eaddr, input logic [15:0] edata,
                           input logic rv, input logic [15:0] rdata, input logic f, input logic [1:0] code);
        vec_t t;
        t.op = op; t.addr = addr; t.data = data;
        t.e.v = v; t.e.op = op; t.e.addr = eaddr; t.e.data = edata;
        t.e.rv = rv; t.e.rdata = rdata; t.e.f = f; t.e.code = code;
        vecs.push_back(t);
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
        bus.i_valid   = 1'b1;
        bus.i_op      = op;
        bus.i_address = addr;
        bus.i_data    = data;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            m_alloc[i] = 1'b0; m_base[i] = 0; m_limit[i] = 0;
        end
    endtask

    // Expected result of one accepted request; updates the model table
    function automatic exp_t model_step(input int op, input int addr, input int data);
        exp_t e;
        int hf, off, id, sel, fid, lim;
        e = '0;
        hf  = (addr >> 12) & 7;
        off = addr % 4096;
        id  = addr & 7;
        sel = (addr >> 3) & 1;
        if (op != 1 && op != 2) return e;
        if (addr < 'h8000) begin
            e.v = 1; e.op = 2'(op); e.addr = 16'(addr); e.data = 16'(data);
        end else if (hf == 7) begin
            if (id == 7) begin
                if (op == 1) begin
                    fid = 7;
                    for (int i = 6; i >= 0; i--) if (!m_alloc[i]) fid = i;
                    e.rv = 1; e.rdata = 16'(fid);
                    if (fid == 7) begin
                        e.f = 1; e.code = 2'd3;
                    end else begin
                        m_alloc[fid] = 1; m_base[fid] = 0; m_limit[fid] = 0;
                    end
                end else begin
                    e.f = 1; e.code = 2'd1;
                end
            end else if (op == 1) begin
                e.rv = 1;
                lim  = BOUNDS_ON ? m_limit[id] : 0;
                e.rdata = !m_alloc[id] ? 16'h0 : (sel == 1) ? 16'(lim) : 16'(m_base[id]);
            end else if (sel == 0) begin
                if (data != 0) begin
                    m_alloc[id] = 1; m_base[id] = data;
                end else begin
                    m_alloc[id] = 0; m_base[id] = 0; m_limit[id] = 0;
                end
            end else if (BOUNDS_ON) begin
                m_limit[id] = data % 8192;
            end
        end else begin
            if (!m_alloc[hf]) begin
                e.f = 1; e.code = 2'd1;
            end else if (BOUNDS_ON && m_limit[hf] != 0 && off >= m_limit[hf]) begin
                e.f = 1; e.code = 2'd2;
            end else begin
                e.v = 1; e.op = 2'(op);
                e.addr = 16'((m_base[hf] + off) % 65536);
                e.data = 16'(data);
            end
        end
        return e;
    endfunction

    task automatic gen_req(output logic [1:0] op, output logic [15:0] addr, output logic [15:0] data);
        int id;
        id   = $urandom_range(0, 6);
        op   = 2'($urandom_range(1, 2));
        data = 16'($urandom);
        case ($urandom_range(0, 6))
            0:       addr = 16'($urandom_range(0, 'h7FFF));
            1, 2:    addr = 16'('h8000 | (id << 12) | ($urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 'hFFF)));
            3: begin op = 2'd1; addr = 16'hF007; end
            4: begin op = 2'd2; addr = 16'('hF000 | id); if ($urandom_range(0, 3) == 0) data = 16'h0; end
            5: begin op = 2'd2; addr = 16'('hF008 | id); data = 16'($urandom_range(0, 48)); end
            default: begin op = 2'd1; addr = 16'('hF000 | ($urandom_range(0, 1) << 3) | id); end
        endcase
        if ($urandom_range(0, 7) == 0) op = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t held, e;
        logic [1:0]  r_op;
        logic [15:0] r_addr, r_data;
        logic        r_v, r_rdy, acc;

        bus.i_valid = 0; bus.i_op = 0; bus.i_address = 0; bus.i_data = 0; bus.i_ready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst o_valid", int'(bus.o_valid), 0);
        check("rst o_resp_valid", int'(bus.o_resp_valid), 0);
        check("rst o_fault", int'(bus.o_fault), 0);
        check("rst o_op", int'(bus.o_op), 0);
        check("rst o_address", int'(bus.o_address), 0);
        check("rst o_data", int'(bus.o_data), 0);
        check("rst o_resp_data", int'(bus.o_resp_data), 0);
        check("rst o_fault_code", int'(bus.o_fault_code), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst o_ready", int'(bus.o_ready), 1);

        // Directed table, applied back-to-back from a clean table
        //       op  addr     data     v  eaddr    edata    rv rdata  f code
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h0, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h1, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h2, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h3, 0, 0);
        add_vec(2, 16'hF002, 16'h0100, 0, 16'h0,   16'h0,   0, 16'h0, 0, 0);
        add_vec(1, 16'hA001, 16'h0,    1, 16'h0101, 16'h0,  0, 16'h0, 0, 0);
        add_vec(2, 16'hA001, 16'h0008, 1, 16'h0101, 16'h8,  0, 16'h0, 0, 0);
        add_vec(2, 16'hF00A, 16'h0010, 0, 16'h0,   16'h0,   0, 16'h0, 0, 0);
`ifdef HANDLE_BOUNDS_CHECK_EN
        add_vec(1, 16'hA010, 16'h0,    0, 16'h0,   16'h0,   0, 16'h0, 1, 2);
        add_vec(1, 16'hF00A, 16'h0,    0, 16'h0,   16'h0,   1, 16'h10, 0, 0);
`else
        add_vec(1, 16'hA010, 16'h0,    1, 16'h0110, 16'h0,  0, 16'h0, 0, 0);
        add_vec(1, 16'hF00A, 16'h0,    0, 16'h0,   16'h0,   1, 16'h0, 0, 0);
`endif
        add_vec(1, 16'hA00F, 16'h0,    1, 16'h010F, 16'h0,  0, 16'h0, 0, 0);
        add_vec(2, 16'hF001, 16'hFFF0, 0, 16'h0,   16'h0,   0, 16'h0, 0, 0);
        add_vec(2, 16'h9020, 16'h55AA, 1, 16'h0010, 16'h55AA, 0, 16'h0, 0, 0);
        add_vec(2, 16'h7FFF, 16'hBEEF, 1, 16'h7FFF, 16'hBEEF, 0, 16'h0, 0, 0);
        add_vec(2, 16'hF002, 16'h0,    0, 16'h0,   16'h0,   0, 16'h0, 0, 0);
        add_vec(1, 16'hA001, 16'h0,    0, 16'h0,   16'h0,   0, 16'h0, 1, 1);
        add_vec(1, 16'hF002, 16'h0,    0, 16'h0,   16'h0,   1, 16'h0, 0, 0);
        add_vec(0, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   0, 16'h0, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h2, 0, 0);
        add_vec(1, 16'hF00A, 16'h0,    0, 16'h0,   16'h0,   1, 16'h0, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h4, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h5, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h6, 0, 0);
        add_vec(1, 16'hF007, 16'h0,    0, 16'h0,   16'h0,   1, 16'h7, 1, 3);
        add_vec(1, 16'h1234, 16'h0,    1, 16'h1234, 16'h0,  0, 16'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].data);
            check_out($sformatf("vec%0d", i), vecs[i].e);
        end

        // Stall: output held and nothing accepted while i_ready is low
        bus.i_ready = 1'b0;
        issue(2'd1, 16'h1234, 16'h0);
        check("stall o_valid", int'(bus.o_valid), 1);
        check("stall o_address", int'(bus.o_address), 'h1234);
        bus.i_valid = 1'b1; bus.i_op = 2'd2; bus.i_address = 16'h4321; bus.i_data = 16'h0777;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d o_ready", k), int'(bus.o_ready), 0);
            check($sformatf("stall%0d o_address", k), int'(bus.o_address), 'h1234);
            check($sformatf("stall%0d o_op", k), int'(bus.o_op), 1);
            @(posedge clk); #1;
        end
        check("stall held o_address", int'(bus.o_address), 'h1234);
        bus.i_ready = 1'b1;
        #1;
        check("release o_ready", int'(bus.o_ready), 1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        check("release o_valid", int'(bus.o_valid), 1);
        check("release o_address", int'(bus.o_address), 'h4321);
        check("release o_data", int'(bus.o_data), 'h0777);
        @(posedge clk); #1;
        check("stall2 o_valid", int'(bus.o_valid), 1);
        // Reset in the middle of a stall drops the held transaction
        do_reset();
        check("rst-stall o_valid", int'(bus.o_valid), 0);
        check("rst-stall o_address", int'(bus.o_address), 0);
        bus.i_ready = 1'b1;

        // Randomized run against the model, with random backpressure
        held = '0;
        for (int n = 0; n < 800; n++) begin
            gen_req(r_op, r_addr, r_data);
            r_v   = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            bus.i_valid = r_v; bus.i_op = r_op; bus.i_address = r_addr;
            bus.i_data = r_data; bus.i_ready = r_rdy;
            #1;
            check($sformatf("rnd%0d o_ready", n), int'(bus.o_ready), int'(!held.v || r_rdy));
            acc = r_v && (!held.v || r_rdy);
            @(posedge clk); #1;
            if (acc) begin
                e = model_step(int'(r_op), int'(r_addr), int'(r_data));
                if (e.v) begin
                    held.v = 1'b1; held.op = e.op; held.addr = e.addr; held.data = e.data;
                end else begin
                    held.v = 1'b0;
                end
            end else begin
                e = '0;
                if (held.v && r_rdy) held.v = 1'b0;
            end
            held.rv = e.rv; held.rdata = e.rdata; held.f = e.f; held.code = e.code;
            check_out($sformatf("rnd%0d", n), held);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
